// File: rtl/activation_lut_loader.sv
// Activation-function LUT write side: loads DEPTH signed breakpoints from a valid/ready
// byte stream and serves the interpolator pair entry[address] / entry[address+1].
module activation_lut_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 17
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         loaded,
    output logic [4:0]                   count,
    input  logic [ADDR_WIDTH-1:0]        address,
    output logic signed [DATA_WIDTH-1:0] base,
    output logic signed [DATA_WIDTH-1:0] next_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);

    state_t                       state;
    state_t                       state_next;
    logic [4:0]                   count_next;
    logic                         loaded_next;
    logic                         wr_en;
    logic [ADDR_WIDTH:0]          base_idx;
    logic [ADDR_WIDTH:0]          next_idx;
    logic signed [DATA_WIDTH-1:0] entries [DEPTH];

    // State, counter, loaded flag and table storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= 5'd0;
            loaded <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            state  <= state_next;
            count  <= count_next;
            loaded <= loaded_next;
            if (wr_en) begin
                entries[count] <= in_data;
            end
        end
    end

    // Next-state logic; a start pulse always wins over a pending transfer.
    always_comb begin
        state_next  = state;
        count_next  = count;
        loaded_next = loaded;
        in_ready    = 1'b0;
        wr_en       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next  = LOAD;
                    count_next  = 5'd0;
                    loaded_next = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                in_ready = ~start;
                if (start) begin
                    count_next  = 5'd0;
                    loaded_next = 1'b0;
                end else if (in_valid) begin
                    wr_en      = 1'b1;
                    count_next = count + 5'd1;
                    if (count == LAST_IDX) begin
                        state_next  = READY;
                        loaded_next = 1'b1;
                    end else begin
                        state_next = LOAD;
                    end
                end else begin
                    state_next = LOAD;
                end
            end
            READY: begin
                if (start) begin
                    state_next  = LOAD;
                    count_next  = 5'd0;
                    loaded_next = 1'b0;
                end else begin
                    state_next = READY;
                end
            end
            default: begin
                state_next  = IDLE;
                count_next  = 5'd0;
                loaded_next = 1'b0;
            end
        endcase
    end

    assign base_idx = {1'b0, address};
    assign next_idx = {1'b0, address} + {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Read port is masked until the table is complete so no partial table leaks out.
    always_comb begin
        base      = '0;
        next_data = '0;
        if (loaded) begin
            base      = entries[base_idx];
            next_data = entries[next_idx];
        end else begin
            base      = '0;
            next_data = '0;
        end
    end

endmodule
